pid_velocity_ctrl: RTL and testbench
====================================

PID_VELOCITY_CTRL -- requirements
Module: pid_velocity_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 9, width of velocity, setpoint and output.
REQ-002 SHALL have parameter GAIN_W, default 4, width of each unsigned gain.
REQ-003 SHALL have parameter FRAC_W, default 2, arithmetic right shift applied to the gain sum.
REQ-004 SHALL have parameter I_LIM, default 1023, symmetric integrator clamp magnitude.
REQ-005 clk  input  1  single rising-edge clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  controller enable; 0 forces idle.
REQ-008 sample_valid  input  1  one-cycle strobe qualifying setpoint and current_vel.
REQ-009 setpoint  input  DATA_W  target velocity, unsigned.
REQ-010 current_vel  input  DATA_W  measured velocity, unsigned.
REQ-011 kp, ki, kd  input  GAIN_W each  proportional, integral and derivative gains, unsigned.
REQ-012 vel_output  output  DATA_W  drive command, unsigned, registered.
REQ-013 out_valid  output  1  one-cycle strobe, vel_output updated this cycle.
REQ-014 busy  output  1  high while a sample is in flight.
REQ-015 sat_flag  output  1  last result clipped at 0 or 2^DATA_W-1.

Function
REQ-016 SHALL use FSM IDLE -> ERR -> MULT -> SUM -> OUT -> IDLE, one cycle per state.
REQ-017 IDLE->ERR only when en=1 and sample_valid=1; inputs and gains captured that cycle.
REQ-018 SHALL ignore sample_valid while busy=1 (no queueing).
REQ-019 busy SHALL be high in ERR, MULT, SUM, OUT.
REQ-020 ERR: e = setpoint - current_vel, signed DATA_W+1 bits; de = e - e_prev.
REQ-021 ERR: integrator acc += e, clamped to [-I_LIM, +I_LIM].
REQ-022 MULT: P=kp*e, I=ki*acc, D=kd*de, signed, full width, no truncation.
REQ-023 SUM: s = (P+I+D) >>> FRAC_W, arithmetic shift.
REQ-024 OUT: vel_output = s saturated to [0, 2^DATA_W-1]; sat_flag=1 if clipped, else 0; e_prev <= e.
REQ-025 out_valid SHALL assert in the cycle after OUT; latency from sample_valid edge to out_valid = 5 cycles.
REQ-026 vel_output and sat_flag SHALL hold between results.
REQ-027 en deasserting mid-operation SHALL let the sample complete; next sample requires en=1.
REQ-028 en=0 in IDLE for any cycle SHALL clear acc and e_prev to 0.

Reset
REQ-029 rst=1 SHALL asynchronously set state=IDLE, vel_output=0, out_valid=0, busy=0, sat_flag=0, acc=0, e_prev=0.
REQ-030 Reset mid-operation SHALL abort the sample with no out_valid pulse.
REQ-031 First sample after reset SHALL use e_prev=0.

Configuration
REQ-032 Macro PID_INTEGRAL_EN defined: integrator, ki and I term active per REQ-021/022.
REQ-033 PID_INTEGRAL_EN undefined: no integrator register, I=0, ki ignored (PD controller); latency unchanged.

Verification
REQ-034 Defaults, rst released, en=1, setpoint=100, current_vel=50, kp=4, ki=0, kd=0 -> 5 cycles later out_valid=1, vel_output=50, sat_flag=0.
REQ-035 Same inputs, kp=4, kd=4, first sample after reset -> vel_output=100; repeat identical sample -> vel_output=50 (de=0).
REQ-036 setpoint=511, current_vel=0, kp=15 -> vel_output=511, sat_flag=1; setpoint=0, current_vel=100, kp=4 -> vel_output=0, sat_flag=1.
REQ-037 PID_INTEGRAL_EN defined, ki=4, kp=kd=0, error=10 for three samples -> vel_output 10, 20, 30; with macro undefined -> 0, 0, 0.
REQ-038 sample_valid pulsed again 2 cycles after accepted sample -> ignored, exactly one out_valid; rst asserted in MULT -> no out_valid, all outputs 0.

Source files
------------

// File: rtl/pid_velocity_if.sv
// Signal bundle between a velocity controller and its sample source / output consumer.
// The master drives the sample and the gains. The slave returns the drive command and status.
interface pid_velocity_if #(
    parameter int DATA_W = 9,
    parameter int GAIN_W = 4
);
    logic              en;
    logic              sample_valid;
    logic [DATA_W-1:0] setpoint;
    logic [DATA_W-1:0] current_vel;
    logic [GAIN_W-1:0] kp;
    logic [GAIN_W-1:0] ki;
    logic [GAIN_W-1:0] kd;
    logic [DATA_W-1:0] vel_output;
    logic              out_valid;
    logic              busy;
    logic              sat_flag;

    modport master (
        output en, sample_valid, setpoint, current_vel, kp, ki, kd,
        input  vel_output, out_valid, busy, sat_flag
    );

    modport slave (
        input  en, sample_valid, setpoint, current_vel, kp, ki, kd,
        output vel_output, out_valid, busy, sat_flag
    );
endinterface

// File: rtl/pid_velocity_ctrl.sv
// Multi-cycle PID velocity controller. Each sample runs through ERR -> MULT -> SUM -> OUT.
// Optional macro PID_INTEGRAL_EN adds the clamped integrator and the ki term.
// Without that macro the block is a PD controller with the same latency.
module pid_velocity_ctrl #(
    parameter int DATA_W = 9,
    parameter int GAIN_W = 4,
    parameter int FRAC_W = 2,
    parameter int I_LIM  = 1023
) (
    input logic         clk,
    input logic         rst,
    pid_velocity_if.slave bus
);
    localparam int E_W   = DATA_W + 1;
    localparam int DE_W  = DATA_W + 2;
    localparam int ACC_W = $clog2(I_LIM + 1) + DATA_W + 2;
    localparam int G_W   = GAIN_W + 1;
    localparam int SUM_W = ACC_W + G_W + 2;

    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, ERR, MULT, SUM, OUT} state_t;

    state_t state, next_state;

    logic [DATA_W-1:0]       sp_r, cv_r, vel_r;
    logic [GAIN_W-1:0]       kp_r, kd_r;
    logic signed [E_W-1:0]   e_r, e_prev, e_calc;
    logic signed [DE_W-1:0]  de_r, de_calc;
    logic signed [SUM_W-1:0] p_r, i_r, d_r, s_r;
    logic signed [G_W-1:0]   gkp, gkd;
    logic                    sat_r, out_valid_r;

    assign e_calc  = $signed({1'b0, sp_r}) - $signed({1'b0, cv_r});
    assign de_calc = DE_W'(e_calc) - DE_W'(e_prev);
    assign gkp     = $signed({1'b0, kp_r});
    assign gkd     = $signed({1'b0, kd_r});

`ifdef PID_INTEGRAL_EN
    localparam logic signed [ACC_W-1:0] I_MAX = ACC_W'(I_LIM);
    localparam logic signed [ACC_W-1:0] I_MIN = -ACC_W'(I_LIM);

    logic [GAIN_W-1:0]       ki_r;
    logic signed [ACC_W-1:0] acc, acc_sum, acc_next;
    logic signed [G_W-1:0]   gki;

    assign gki     = $signed({1'b0, ki_r});
    assign acc_sum = acc + ACC_W'(e_calc);

    // Integrator update, clamped symmetrically so the I term cannot wind up without bound.
    always_comb begin
        acc_next = acc_sum;
        if (acc_sum > I_MAX) begin
            acc_next = I_MAX;
        end else if (acc_sum < I_MIN) begin
            acc_next = I_MIN;
        end
    end
`else
    wire unused_ki = ^bus.ki;
`endif

    // State register. Reset drops any sample that is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencing. A new sample is accepted only from IDLE, so strobes that arrive while busy are dropped.
    always_comb begin
        next_state = state;
        bus.busy   = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.en && bus.sample_valid) begin
                    next_state = ERR;
                end
            end
            ERR:     next_state = MULT;
            MULT:    next_state = SUM;
            SUM:     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath. Each stage is registered, and the result and its valid strobe are registered together in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r        <= '0;
            cv_r        <= '0;
            kp_r        <= '0;
            kd_r        <= '0;
            e_r         <= '0;
            de_r        <= '0;
            e_prev      <= '0;
            p_r         <= '0;
            i_r         <= '0;
            d_r         <= '0;
            s_r         <= '0;
            vel_r       <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef PID_INTEGRAL_EN
            ki_r        <= '0;
            acc         <= '0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.en) begin
                        e_prev <= '0;
`ifdef PID_INTEGRAL_EN
                        acc    <= '0;
`endif
                    end else if (bus.sample_valid) begin
                        sp_r <= bus.setpoint;
                        cv_r <= bus.current_vel;
                        kp_r <= bus.kp;
                        kd_r <= bus.kd;
`ifdef PID_INTEGRAL_EN
                        ki_r <= bus.ki;
`endif
                    end
                end
                ERR: begin
                    e_r  <= e_calc;
                    de_r <= de_calc;
`ifdef PID_INTEGRAL_EN
                    acc  <= acc_next;
`endif
                end
                MULT: begin
                    p_r <= SUM_W'(gkp) * SUM_W'(e_r);
                    d_r <= SUM_W'(gkd) * SUM_W'(de_r);
`ifdef PID_INTEGRAL_EN
                    i_r <= SUM_W'(gki) * SUM_W'(acc);
`else
                    i_r <= '0;
`endif
                end
                SUM: begin
                    s_r <= (p_r + i_r + d_r) >>> FRAC_W;
                end
                OUT: begin
                    if (s_r < 0) begin
                        vel_r <= '0;
                        sat_r <= 1'b1;
                    end else if (s_r > OUT_MAX) begin
                        vel_r <= '1;
                        sat_r <= 1'b1;
                    end else begin
                        vel_r <= s_r[DATA_W-1:0];
                        sat_r <= 1'b0;
                    end
                    e_prev      <= e_r;
                    out_valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.vel_output = vel_r;
    assign bus.sat_flag   = sat_r;
    assign bus.out_valid  = out_valid_r;
endmodule

// File: tb/tb_pid_velocity_ctrl.sv
// Self-checking bench for pid_velocity_ctrl at the default parameters.
// Expected values come from fixed vectors and from a plain-integer reference model.
module tb_pid_velocity_ctrl;
    localparam int DATA_W = 9;
    localparam int GAIN_W = 4;
    localparam int FRAC_W = 2;
    localparam int I_LIM  = 1023;
    localparam int VMAX   = (1 << DATA_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int   m_eprev;
    int   m_acc;

    pid_velocity_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus ();

    pid_velocity_ctrl #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W), .I_LIM(I_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int sp;
        int cv;
        int kp;
        int kd;
        int vel;
        bit sat;
    } vec_t;

    vec_t vecs[7];

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference model: a controller computed directly with integer arithmetic.
    function automatic void model(input int sp, input int cv, input int kp, input int ki,
                                  input int kd, output int vel, output bit sat);
        int e, de, s;
        e  = sp - cv;
        de = e - m_eprev;
`ifdef PID_INTEGRAL_EN
        m_acc = m_acc + e;
        if (m_acc > I_LIM) m_acc = I_LIM;
        if (m_acc < -I_LIM) m_acc = -I_LIM;
        s = kp * e + ki * m_acc + kd * de;
`else
        s = kp * e + kd * de;
`endif
        s = s >>> FRAC_W;
        m_eprev = e;
        if (s < 0) begin
            vel = 0;
            sat = 1'b1;
        end else if (s > VMAX) begin
            vel = VMAX;
            sat = 1'b1;
        end else begin
            vel = s;
            sat = 1'b0;
        end
    endfunction

    // Drive one sample, then wait a bounded time for its result and record the latency.
    task automatic applyStimulus(input int sp, input int cv, input int kp, input int ki,
                                 input int kd, output int vel, output int sat, output int lat);
        int busy_seen;
        @(negedge clk);
        bus.setpoint     = DATA_W'(sp);
        bus.current_vel  = DATA_W'(cv);
        bus.kp           = GAIN_W'(kp);
        bus.ki           = GAIN_W'(ki);
        bus.kd           = GAIN_W'(kd);
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        busy_seen = int'(bus.busy);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vel = int'(bus.vel_output);
        sat = int'(bus.sat_flag);
        checkOutput("busy_after_accept", busy_seen, 1);
    endtask

    // Drop en for one idle cycle, which clears the controller history.
    task automatic clearHistory();
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        m_eprev = 0;
        m_acc   = 0;
    endtask

    initial begin
        int vel, sat, lat, exp_vel, pulses, got;
        bit exp_sat;
        int sp, cv, kp, ki, kd;

        checks   = 0;
        failures = 0;
        m_eprev  = 0;
        m_acc    = 0;

        vecs[0] = '{sp: 100, cv: 50,  kp: 4,  kd: 0,  vel: 50,  sat: 1'b0};
        vecs[1] = '{sp: 100, cv: 50,  kp: 4,  kd: 4,  vel: 100, sat: 1'b0};
        vecs[2] = '{sp: 511, cv: 0,   kp: 15, kd: 0,  vel: 511, sat: 1'b1};
        vecs[3] = '{sp: 0,   cv: 100, kp: 4,  kd: 0,  vel: 0,   sat: 1'b1};
        vecs[4] = '{sp: 200, cv: 180, kp: 3,  kd: 2,  vel: 25,  sat: 1'b0};
        vecs[5] = '{sp: 300, cv: 301, kp: 0,  kd: 15, vel: 0,   sat: 1'b1};
        vecs[6] = '{sp: 3,   cv: 0,   kp: 1,  kd: 0,  vel: 0,   sat: 1'b0};

        rst              = 1'b1;
        bus.en           = 1'b0;
        bus.sample_valid = 1'b0;
        bus.setpoint     = '0;
        bus.current_vel  = '0;
        bus.kp           = '0;
        bus.ki           = '0;
        bus.kd           = '0;
        #12;
        checkOutput("reset_vel", int'(bus.vel_output), 0);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_sat", int'(bus.sat_flag), 0);
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b1;

        // Fixed vectors, each one run as the first sample after the history is cleared.
        for (int i = 0; i < 7; i++) begin
            clearHistory();
            applyStimulus(vecs[i].sp, vecs[i].cv, vecs[i].kp, 0, vecs[i].kd, vel, sat, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 5);
            checkOutput($sformatf("vec%0d_vel", i), vel, vecs[i].vel);
            checkOutput($sformatf("vec%0d_sat", i), sat, int'(vecs[i].sat));
        end

        // Repeating an identical sample gives de=0, so only the P term remains.
        clearHistory();
        applyStimulus(100, 50, 4, 0, 4, vel, sat, lat);
        checkOutput("pd_first_vel", vel, 100);
        applyStimulus(100, 50, 4, 0, 4, vel, sat, lat);
        checkOutput("pd_repeat_vel", vel, 50);

        // Integral-only control with a constant error of 10 over three samples.
        clearHistory();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(60, 50, 0, 4, 0, vel, sat, lat);
`ifdef PID_INTEGRAL_EN
            checkOutput($sformatf("integ_vel%0d", i), vel, 10 * i);
`else
            checkOutput($sformatf("integ_vel%0d", i), vel, 0);
`endif
            checkOutput($sformatf("integ_sat%0d", i), sat, 0);
        end

        // A second strobe while busy is dropped. Only one result appears, and it comes from the first sample.
        clearHistory();
        model(120, 100, 4, 0, 0, exp_vel, exp_sat);
        @(negedge clk);
        bus.setpoint = 9'd120; bus.current_vel = 9'd100;
        bus.kp = 4'd4; bus.ki = 4'd0; bus.kd = 4'd0;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        bus.setpoint = 9'd500; bus.current_vel = 9'd0; bus.kp = 4'd15;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        pulses = 0;
        got = -1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                pulses++;
                got = int'(bus.vel_output);
            end
        end
        checkOutput("overlap_pulses", pulses, 1);
        checkOutput("overlap_vel", got, exp_vel);

        // Reset during MULT aborts the sample and clears all outputs.
        @(negedge clk);
        bus.setpoint = 9'd400; bus.current_vel = 9'd0; bus.kp = 4'd2;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_vel", int'(bus.vel_output), 0);
        checkOutput("abort_sat", int'(bus.sat_flag), 0);
        checkOutput("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        m_eprev = 0;
        m_acc   = 0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        checkOutput("abort_pulses", pulses, 0);

        // Random samples compared against the reference model, with the history cleared now and then.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) clearHistory();
            sp = int'($urandom_range(0, VMAX));
            cv = int'($urandom_range(0, VMAX));
            kp = int'($urandom_range(0, 15));
            ki = int'($urandom_range(0, 15));
            kd = int'($urandom_range(0, 15));
            model(sp, cv, kp, ki, kd, exp_vel, exp_sat);
            applyStimulus(sp, cv, kp, ki, kd, vel, sat, lat);
            checkOutput($sformatf("rand%0d_latency", n), lat, 5);
            checkOutput($sformatf("rand%0d_vel", n), vel, exp_vel);
            checkOutput($sformatf("rand%0d_sat", n), sat, int'(exp_sat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
